psg_bus_sequencer: RTL and testbench

Host-side write controller for the AY-3-8913 PSG core. It accepts register-write requests (4-bit register number plus 8-bit value) over a valid/ready handshake and buffers them in a small FIFO. It then drives the PSG's BDIR/BC1/DA bus with correctly ordered latch-address and write-data cycles. It lets a CPU, sequencer or test pattern program the PSG without meeting bus timing itself.

---
 rtl/psg_bus_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_psg_bus_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/psg_bus_sequencer.sv
// psg_bus_sequencer
//   Host-side write controller for the AY-3-8913 PSG core. Register writes
//   (4-bit register number + 8-bit value) arrive over a valid/ready handshake,
//   are queued in a small FIFO, and are replayed onto the PSG BDIR/BC1/DA bus
//   as a LATCH (address) phase followed by a WRITE (data) phase.
//
// Parameters
//   FIFO_DEPTH          request FIFO entries, power of two, 2..16
//   HOLD_CYCLES         clocks each LATCH / WRITE phase is held, 1..15
//   UPPER_ADDRESS_MASK  DA7..DA4 during LATCH (PSG chip-select mask)
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   req_valid/req_ready request handshake (req_ready = FIFO not full)
//   req_reg, req_data   target register and value
//   bus_data            PSG DA7..DA0 (registered)
//   bus_bdir, bus_bc1   PSG BDIR / BC1 (registered)
//   busy                work queued, in flight, or still visible on the bus
//   fifo_level          occupied FIFO entries
//
// Optional feature
//   PSG_BUS_ADDR_CACHE_EN: remember the last latched register; a request to
//   the same register skips the LATCH phase and goes straight to WRITE.

module psg_bus_sequencer #(
  parameter int         FIFO_DEPTH         = 4,
  parameter int         HOLD_CYCLES        = 1,
  parameter logic [3:0] UPPER_ADDRESS_MASK = 4'b0000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [3:0]                    req_reg,
  input  logic [7:0]                    req_data,
  output logic [7:0]                    bus_data,
  output logic                          bus_bdir,
  output logic                          bus_bc1,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int         AW   = $clog2(FIFO_DEPTH);
  localparam int         LW   = AW + 1;
  localparam logic [3:0] HOLD = 4'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [11:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic          push, pop, fifo_empty;
  logic [3:0]    head_reg;
  logic [7:0]    head_data;

  assign fifo_empty = (count == '0);
  assign req_ready  = (count != LW'(FIFO_DEPTH));
  assign push       = req_valid && req_ready;
  assign head_reg   = mem[rd_ptr][11:8];
  assign head_data  = mem[rd_ptr][7:0];
  assign fifo_level = count;

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {req_reg, req_data};
  end

  // -------------------------------------------------- address cache option
  logic cache_hit;

`ifdef PSG_BUS_ADDR_CACHE_EN
  logic [3:0] cache_reg;
  logic       cache_vld;

  assign cache_hit = cache_vld && (cache_reg == head_reg);

  // Updated only when a real LATCH is issued, so it always mirrors the
  // address the PSG currently holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      cache_reg <= '0;
      cache_vld <= 1'b0;
    end else if (pop && !cache_hit) begin
      cache_reg <= head_reg;
      cache_vld <= 1'b1;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // ----------------------------------------------------------------- FSM
  state_t     state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic [3:0] cur_reg;
  logic [7:0] cur_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // IDLE pops at most once per visit, so IDLE always lasts >= 1 clock.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          hold_d  = HOLD;
          state_d = cache_hit ? ST_WRITE : ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (hold_q == 4'd1) begin
          hold_d  = HOLD;
          state_d = ST_WRITE;
        end else begin
          hold_d  = hold_q - 4'd1;
        end
      end
      ST_WRITE: begin
        if (hold_q == 4'd1) begin
          state_d = ST_IDLE;
        end else begin
          hold_d  = hold_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Popped entry is held here for the whole transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_reg  <= '0;
      cur_data <= '0;
    end else if (pop) begin
      cur_reg  <= head_reg;
      cur_data <= head_data;
    end
  end

  // ------------------------------------------------------- bus registers
  // Driven from the current state, so the bus lags the FSM by one clock.
  // In IDLE bus_data keeps the last written value: the PSG rewrites its
  // latched register on every non-latch clock, and holding the data makes
  // those rewrites harmless.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_bdir <= 1'b0;
      bus_bc1  <= 1'b0;
      bus_data <= '0;
    end else begin
      case (state_q)
        ST_LATCH: begin
          bus_bdir <= 1'b1;
          bus_bc1  <= 1'b1;
          bus_data <= {UPPER_ADDRESS_MASK, cur_reg};
        end
        ST_WRITE: begin
          bus_bdir <= 1'b1;
          bus_bc1  <= 1'b0;
          bus_data <= cur_data;
        end
        default: begin
          bus_bdir <= 1'b0;
          bus_bc1  <= 1'b0;
        end
      endcase
    end
  end

  // bus_bdir term keeps busy high until the final WRITE has left the bus,
  // so busy falls in the bus IDLE cycle that follows it.
  assign busy = !fifo_empty || (state_q != ST_IDLE) || bus_bdir;

endmodule

// File: tb/tb_psg_bus_sequencer.sv
module tb_psg_bus_sequencer;
  localparam int         DEPTH = 4;
  localparam int         H     = 2;
  localparam logic [3:0] MASK  = 4'h5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [3:0] req_reg = '0;
  logic [7:0] req_data = '0;
  logic       req_ready, bus_bdir, bus_bc1, busy;
  logic [7:0] bus_data;
  logic [$clog2(DEPTH):0] fifo_level;

  always #5 clk = ~clk;

  psg_bus_sequencer #(
    .FIFO_DEPTH(DEPTH), .HOLD_CYCLES(H), .UPPER_ADDRESS_MASK(MASK)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_reg(req_reg), .req_data(req_data),
    .bus_data(bus_data), .bus_bdir(bus_bdir), .bus_bc1(bus_bc1),
    .busy(busy), .fifo_level(fifo_level)
  );

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ------------------------------------------------------------ model
  // Each accepted request becomes a scheduled transaction: bus start cycle s,
  // length len (LATCH+WRITE, or WRITE only on an address-cache hit).
  // Cycle k means "state visible after clock edge k".
  int         t_acc[$], t_s[$], t_len[$];
  bit         t_hit[$];
  logic [3:0] t_reg[$];
  logic [7:0] t_data[$];
  logic [3:0] m_cache = '0;
  bit         m_cache_v = 1'b0;

  task automatic m_clear();
    t_acc.delete(); t_s.delete(); t_len.delete();
    t_hit.delete(); t_reg.delete(); t_data.delete();
    m_cache_v = 1'b0;
  endtask

  task automatic m_push(input int acc, input logic [3:0] r, input logic [7:0] d);
    int s = acc + 2;
    bit hit = 1'b0;
    if (t_s.size() > 0 && t_s[$] + t_len[$] + 1 > s) s = t_s[$] + t_len[$] + 1;
`ifdef PSG_BUS_ADDR_CACHE_EN
    hit = m_cache_v && (m_cache == r);
    m_cache = r;
    m_cache_v = 1'b1;
`endif
    t_acc.push_back(acc); t_s.push_back(s); t_len.push_back(hit ? H : 2*H);
    t_hit.push_back(hit); t_reg.push_back(r); t_data.push_back(d);
  endtask

  // Entries accepted but not yet popped (pop happens one edge before bus start).
  function automatic int m_level(input int k);
    int n = 0;
    foreach (t_acc[i]) if (t_acc[i] <= k && t_s[i] - 1 > k) n++;
    return n;
  endfunction

  task automatic m_expect(input int k, output logic bdir, output logic bc1,
                          output logic [7:0] data, output logic bsy);
    bdir = 1'b0; bc1 = 1'b0; data = 8'h00;
    bsy = (m_level(k) > 0);
    foreach (t_s[i]) begin
      if (t_s[i] + t_len[i] <= k) data = t_data[i];
      if (t_s[i] - 1 <= k && k < t_s[i] + t_len[i]) bsy = 1'b1;
      if (t_s[i] <= k && k < t_s[i] + t_len[i]) begin
        bdir = 1'b1;
        if (!t_hit[i] && k < t_s[i] + H) begin
          bc1 = 1'b1; data = {MASK, t_reg[i]};
        end else begin
          bc1 = 1'b0; data = t_data[i];
        end
      end
    end
  endtask

  // ---------------------------------------------------------- compare
  always @(negedge clk) begin
    logic eb, ec, ebsy;
    logic [7:0] ed;
    if (check_en) begin
      m_expect(cyc, eb, ec, ed, ebsy);
      check("bus_bdir",   32'(bus_bdir),   32'(eb));
      check("bus_bc1",    32'(bus_bc1),    32'(ec));
      check("bus_data",   32'(bus_data),   32'(ed));
      check("busy",       32'(busy),       32'(ebsy));
      check("fifo_level", 32'(fifo_level), 32'(m_level(cyc)));
      check("req_ready",  32'(req_ready),  32'(m_level(cyc) < DEPTH));
    end
  end

  // --------------------------------------------------------- stimulus
  task automatic step(input bit v, input logic [3:0] r, input logic [7:0] d, output bit acc);
    req_valid = v; req_reg = r; req_data = d;
    acc = v && (m_level(cyc) < DEPTH);
    @(posedge clk);
    cyc++;
    if (acc) m_push(cyc, r, d);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle();
    bit a;
    step(1'b0, 4'h0, 8'h00, a);
  endtask

  task automatic push_one(input logic [3:0] r, input logic [7:0] d);
    bit a = 1'b0;
    for (int t = 0; t < 100 && !a; t++) step(1'b1, r, d, a);
    if (!a) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = 1'b0;
    @(posedge clk);
    cyc++;
    m_clear();
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int n0;
    logic [3:0] rr;
    logic [7:0] dd;
    bit a;

    do_reset();
    do_reset();
    check_en = 1'b1;
    check("rst_bus",   32'({bus_bdir, bus_bc1, bus_data}), 32'h000);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ready", 32'(req_ready),  32'd1);
    check("rst_busy",  32'(busy),       32'd0);

    // Single write R7 <= 0x38
    push_one(4'd7, 8'h38);
    n0 = cyc;
    repeat (7) begin
      idle();
      case (cyc - n0)
        2: check("t1_latch", 32'({bus_bdir, bus_bc1, bus_data}), 32'h357);
        4: check("t1_write", 32'({bus_bdir, bus_bc1, bus_data}), 32'h238);
        5: check("t1_busy_hi", 32'(busy), 32'd1);
        6: begin
             check("t1_idle", 32'({bus_bdir, bus_bc1, bus_data}), 32'h038);
             check("t1_busy_lo", 32'(busy), 32'd0);
           end
        default: ;
      endcase
    end

    // Five back-to-back pushes fill the FIFO, then reset mid-WRITE
    push_one(4'd0, 8'h11);
    n0 = cyc;
    push_one(4'd1, 8'h02);
    push_one(4'd8, 8'h0F);
    push_one(4'd6, 8'h1F);
    push_one(4'd2, 8'hAA);
    check("t2_acc_time", 32'(cyc - n0), 32'd4);
    while (cyc - n0 < 9 && cyc - n0 >= 0) begin
      idle();
      case (cyc - n0)
        5: begin
             check("t2_full_level", 32'(fifo_level), 32'd4);
             check("t2_full_ready", 32'(req_ready),  32'd0);
           end
        6: check("t2_level_drop", 32'(fifo_level), 32'd3);
        7: check("t2_latch_r1", 32'({bus_bdir, bus_bc1, bus_data}), 32'h351);
        9: check("t2_write_r1", 32'({bus_bdir, bus_bc1, bus_data}), 32'h202);
        default: ;
      endcase
    end
    do_reset();
    check("t5_bus",   32'({bus_bdir, bus_bc1, bus_data}), 32'h000);
    check("t5_level", 32'(fifo_level), 32'd0);
    check("t5_busy",  32'(busy),       32'd0);
    check("t5_ready", 32'(req_ready),  32'd1);

    // Two writes to the same register
    push_one(4'd11, 8'h10);
    n0 = cyc;
    push_one(4'd11, 8'h20);
    repeat (7) begin
      idle();
`ifdef PSG_BUS_ADDR_CACHE_EN
      if (cyc - n0 == 7) check("t6_second", 32'({bus_bdir, bus_bc1, bus_data}), 32'h220);
`else
      if (cyc - n0 == 7) check("t6_second", 32'({bus_bdir, bus_bc1, bus_data}), 32'h35B);
`endif
    end

    // Randomised traffic in phases: sparse, same-register heavy, saturating
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 1000; i++) begin
        if ($urandom_range(0, 399) == 0) begin
          do_reset();
        end else begin
          rr = (ph == 1) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
          dd = 8'($urandom);
          case (ph)
            0:       step($urandom_range(0, 9) == 0, rr, dd, a);
            1:       step($urandom_range(0, 2) == 0, rr, dd, a);
            default: step($urandom_range(0, 3) != 0, rr, dd, a);
          endcase
        end
      end
    end
    repeat (120) idle();

    @(negedge clk);
    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
